// File: rtl/pa_rvfpm.sv
// Shared types and constants for the RVFPM floating-point XIF issue path.
// Holds the per-entry status struct and the legal queue depth range.
package pa_rvfpm;

  localparam int QUEUE_DEPTH_MIN = 2;
  localparam int QUEUE_DEPTH_MAX = 16;

  // Status bits carried by every issue queue entry.
  typedef struct packed {
    logic valid;
    logic committed;
    logic killed;
  } q_status_t;

  // True when a requested queue depth is within the supported range.
  function automatic logic depth_ok(input int depth);
    return (depth >= QUEUE_DEPTH_MIN) && (depth <= QUEUE_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/fp_xif_id_match.sv
// Commit ID matcher for the FP XIF issue queue.
// Builds a one-hot match vector of candidate entries carrying the commit ID
// and selects the matching entry closest to the queue head.
module fp_xif_id_match #(
  parameter int DEPTH = 4,
  parameter int IDW   = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_cand,
  input  logic [IDW-1:0]   i_ids [DEPTH],
  input  logic [IDW-1:0]   i_id,
  input  logic [PW-1:0]    i_head,
  output logic             o_hit,
  output logic [PW-1:0]    o_idx
);

  logic [DEPTH-1:0] w_match;

  // Flag every candidate entry whose stored ID equals the commit ID.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_match[k] = i_cand[k] && (i_ids[k] == i_id);
    end
  end

  // Walk from the head towards the tail so the oldest duplicate wins.
  always_comb begin
    logic [PW:0] pos;
    o_hit = 1'b0;
    o_idx = '0;
    pos   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = {1'b0, i_head} + (PW+1)'(k);
      if (pos >= (PW+1)'(DEPTH)) begin
        pos = pos - (PW+1)'(DEPTH);
      end
      if (!o_hit && w_match[pos[PW-1:0]]) begin
        o_hit = 1'b1;
        o_idx = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_xif_issue_queue.sv
// In-order issue queue between the CORE-V-XIF issue/commit interface and the
// FPU execute stage. Entries are dispatched from the head only once committed;
// killed entries are dropped silently when they reach the head.
// Optional feature: define RVFPM_QUEUE_HWM_EN to add the hwm (high-water mark)
// output tracking the largest occupancy seen since reset.
module fp_xif_issue_queue
  import pa_rvfpm::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int X_ID_WIDTH  = 4,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                             ck,
  input  logic                             rst,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [INSTR_WIDTH-1:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0]            issue_id,
  input  logic                             pd_accept,
  output logic                             issue_accept,
  input  logic                             commit_valid,
  input  logic [X_ID_WIDTH-1:0]            commit_id,
  input  logic                             commit_kill,
  output logic                             exec_valid,
  input  logic                             exec_ready,
  output logic [INSTR_WIDTH-1:0]           exec_instr,
  output logic [X_ID_WIDTH-1:0]            exec_id,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] count,
  output logic                             full,
  output logic                             empty
`ifdef RVFPM_QUEUE_HWM_EN
  ,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] hwm
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);

  if (!depth_ok(QUEUE_DEPTH)) begin : g_bad_depth
    $error("fp_xif_issue_queue: QUEUE_DEPTH out of range");
  end

  typedef struct packed {
    q_status_t              st;
    logic [INSTR_WIDTH-1:0] instr;
    logic [X_ID_WIDTH-1:0]  id;
  } entry_t;

  entry_t          r_entries [QUEUE_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  entry_t          w_head_entry;
  logic            w_push;
  logic            w_pop;
  logic            w_hit;
  logic [PW-1:0]   w_hit_idx;
  logic            w_commit_new;
  logic [QUEUE_DEPTH-1:0] w_cand;
  logic [X_ID_WIDTH-1:0]  w_ids [QUEUE_DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (r_count == CW'(QUEUE_DEPTH));
  assign empty        = (r_count == '0);
  assign count        = r_count;
  assign issue_ready  = !full;
  assign issue_accept = issue_valid && issue_ready && pd_accept;

  assign w_head_entry = r_entries[r_head];
  assign exec_valid   = w_head_entry.st.valid && w_head_entry.st.committed && !w_head_entry.st.killed;
  assign exec_instr   = w_head_entry.instr;
  assign exec_id      = w_head_entry.id;

  assign w_push = issue_accept;
  assign w_pop  = (exec_valid && exec_ready) ||
                  (w_head_entry.st.valid && w_head_entry.st.committed && w_head_entry.st.killed);

  // Only valid, not-yet-committed entries can take a commit.
  always_comb begin
    w_cand = '0;
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      w_cand[k] = r_entries[k].st.valid && !r_entries[k].st.committed;
      w_ids[k]  = r_entries[k].id;
    end
  end

  fp_xif_id_match #(
    .DEPTH (QUEUE_DEPTH),
    .IDW   (X_ID_WIDTH),
    .PW    (PW)
  ) u_id_match (
    .i_cand (w_cand),
    .i_ids  (w_ids),
    .i_id   (commit_id),
    .i_head (r_head),
    .o_hit  (w_hit),
    .o_idx  (w_hit_idx)
  );

  // A commit that finds no stored match may target the entry being written now.
  assign w_commit_new = commit_valid && !w_hit && w_push && (issue_id == commit_id);

  // Queue state: commit marking, tail write on accept, head release on pop.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        r_entries[k] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (commit_valid && w_hit) begin
        r_entries[w_hit_idx].st.committed <= 1'b1;
        r_entries[w_hit_idx].st.killed    <= commit_kill;
      end
      if (w_push) begin
        r_entries[r_tail].st.valid     <= 1'b1;
        r_entries[r_tail].st.committed <= w_commit_new;
        r_entries[r_tail].st.killed    <= w_commit_new && commit_kill;
        r_entries[r_tail].instr        <= issue_instr;
        r_entries[r_tail].id           <= issue_id;
        r_tail                         <= next_ptr(r_tail);
      end
      if (w_pop) begin
        r_entries[r_head].st <= '0;
        r_head               <= next_ptr(r_head);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef RVFPM_QUEUE_HWM_EN
  logic [CW-1:0] r_hwm;

  // Track the peak occupancy, lagging the count register by one cycle.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_hwm <= '0;
    end else if (r_count > r_hwm) begin
      r_hwm <= r_count;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_fp_xif_issue_queue.sv
// Directed testbench for fp_xif_issue_queue at default parameters.
// Checks the hwm output as well when RVFPM_QUEUE_HWM_EN is defined.
module tb_fp_xif_issue_queue;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          ck;
  logic          rst;
  logic          issue_valid;
  logic          issue_ready;
  logic [IW-1:0] issue_instr;
  logic [IDW-1:0] issue_id;
  logic          pd_accept;
  logic          issue_accept;
  logic          commit_valid;
  logic [IDW-1:0] commit_id;
  logic          commit_kill;
  logic          exec_valid;
  logic          exec_ready;
  logic [IW-1:0] exec_instr;
  logic [IDW-1:0] exec_id;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
`ifdef RVFPM_QUEUE_HWM_EN
  logic [CW-1:0] hwm;
`endif

  int tests = 0;
  int fails = 0;
  logic inKillTest = 1'b0;
  logic sawKilledDispatch = 1'b0;

  fp_xif_issue_queue #(
    .QUEUE_DEPTH (DEPTH),
    .X_ID_WIDTH  (IDW),
    .INSTR_WIDTH (IW)
  ) dut (
    .ck           (ck),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_instr  (issue_instr),
    .issue_id     (issue_id),
    .pd_accept    (pd_accept),
    .issue_accept (issue_accept),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_kill  (commit_kill),
    .exec_valid   (exec_valid),
    .exec_ready   (exec_ready),
    .exec_instr   (exec_instr),
    .exec_id      (exec_id),
    .count        (count),
    .full         (full),
    .empty        (empty)
`ifdef RVFPM_QUEUE_HWM_EN
    ,
    .hwm          (hwm)
`endif
  );

  // Free-running clock.
  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Record any dispatch of the killed instruction during the kill scenario.
  always @(negedge ck) begin
    if (inKillTest && exec_valid && exec_id == 4'd3) sawKilledDispatch = 1'b1;
  end

  task automatic idle();
    issue_valid  = 1'b0;
    issue_instr  = '0;
    issue_id     = '0;
    pd_accept    = 1'b0;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
    exec_ready   = 1'b0;
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_issue(input logic [IDW-1:0] id, input logic [IW-1:0] instr);
    issue_valid = 1'b1;
    pd_accept   = 1'b1;
    issue_id    = id;
    issue_instr = instr;
    tick();
    issue_valid = 1'b0;
    pd_accept   = 1'b0;
  endtask

  task automatic do_commit(input logic [IDW-1:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    tick();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    issue_valid = 1'b1;
    pd_accept = 1'b1;
    issue_id = 4'd6;
    tick();
    rst = 1'b0;
    idle();
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL reset_empty: got %0b expected 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full: got %0b expected 0", full); end
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_issue_ready: got %0b expected 1", issue_ready); end
    tests++; if (exec_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_exec_valid: got %0b expected 0", exec_valid); end
    tests++; if (exec_id !== 4'd0 || exec_instr !== 32'd0) begin fails++; $display("[TB] FAIL reset_exec_data: got id %0h instr %0h expected 0 0", exec_id, exec_instr); end
`ifdef RVFPM_QUEUE_HWM_EN
    tests++; if (hwm !== 3'd0) begin fails++; $display("[TB] FAIL reset_hwm: got %0d expected 0", hwm); end
`endif
  endtask

  task automatic test_in_order();
    do_reset();
    do_issue(4'd1, 32'hA000_0001);
    do_issue(4'd2, 32'hA000_0002);
    do_issue(4'd3, 32'hA000_0003);
    tests++; if (count !== 3'd3) begin fails++; $display("[TB] FAIL inorder_count: got %0d expected 3", count); end
    tests++; if (exec_valid !== 1'b0) begin fails++; $display("[TB] FAIL inorder_uncommitted: got %0b expected 0", exec_valid); end
    do_commit(4'd1, 1'b0);
    do_commit(4'd2, 1'b0);
    do_commit(4'd3, 1'b0);
`ifdef RVFPM_QUEUE_HWM_EN
    tests++; if (hwm !== 3'd3) begin fails++; $display("[TB] FAIL inorder_hwm: got %0d expected 3", hwm); end
`endif
    exec_ready = 1'b1;
    #1;
    tests++; if (exec_valid !== 1'b1 || exec_id !== 4'd1 || exec_instr !== 32'hA000_0001) begin fails++; $display("[TB] FAIL inorder_first: got v%0b id %0d instr %0h expected v1 id 1 instr a0000001", exec_valid, exec_id, exec_instr); end
    tick();
    tests++; if (exec_valid !== 1'b1 || exec_id !== 4'd2) begin fails++; $display("[TB] FAIL inorder_second: got v%0b id %0d expected v1 id 2", exec_valid, exec_id); end
    tick();
    tests++; if (exec_valid !== 1'b1 || exec_id !== 4'd3 || exec_instr !== 32'hA000_0003) begin fails++; $display("[TB] FAIL inorder_third: got v%0b id %0d instr %0h expected v1 id 3 instr a0000003", exec_valid, exec_id, exec_instr); end
    tick();
    tests++; if (empty !== 1'b1 || exec_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("[TB] FAIL inorder_drained: got empty %0b v%0b count %0d expected 1 0 0", empty, exec_valid, count); end
    exec_ready = 1'b0;
  endtask

  task automatic test_reject();
    do_reset();
    issue_valid = 1'b1;
    pd_accept = 1'b0;
    issue_id = 4'd5;
    issue_instr = 32'hBBBB_0005;
    #1;
    tests++; if (issue_accept !== 1'b0) begin fails++; $display("[TB] FAIL reject_accept: got %0b expected 0", issue_accept); end
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("[TB] FAIL reject_ready: got %0b expected 1", issue_ready); end
    tick();
    idle();
    #1;
    tests++; if (count !== 3'd0 || empty !== 1'b1) begin fails++; $display("[TB] FAIL reject_count: got count %0d empty %0b expected 0 1", count, empty); end
    tests++; if (exec_valid !== 1'b0) begin fails++; $display("[TB] FAIL reject_dispatch: got %0b expected 0", exec_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 1; i <= 4; i++) do_issue(IDW'(i), 32'hC000_0000 + 32'(i));
    tests++; if (full !== 1'b1 || issue_ready !== 1'b0 || count !== 3'd4) begin fails++; $display("[TB] FAIL full_flags: got full %0b ready %0b count %0d expected 1 0 4", full, issue_ready, count); end
    issue_valid = 1'b1;
    pd_accept = 1'b1;
    issue_id = 4'd5;
    issue_instr = 32'hC000_0005;
    commit_valid = 1'b1;
    commit_id = 4'd1;
    #1;
    tests++; if (issue_accept !== 1'b0) begin fails++; $display("[TB] FAIL full_blocks_issue: got %0b expected 0", issue_accept); end
    tick();
    commit_valid = 1'b0;
    exec_ready = 1'b1;
    #1;
    tests++; if (exec_valid !== 1'b1 || exec_id !== 4'd1 || issue_accept !== 1'b0) begin fails++; $display("[TB] FAIL full_pop_cycle: got v%0b id %0d acc %0b expected v1 id 1 acc 0", exec_valid, exec_id, issue_accept); end
    tick();
    exec_ready = 1'b0;
    #1;
    tests++; if (count !== 3'd3 || issue_accept !== 1'b1) begin fails++; $display("[TB] FAIL full_after_pop: got count %0d acc %0b expected 3 1", count, issue_accept); end
    tick();
    idle();
    tests++; if (count !== 3'd4 || full !== 1'b1) begin fails++; $display("[TB] FAIL full_refill: got count %0d full %0b expected 4 1", count, full); end
    for (int i = 2; i <= 5; i++) do_commit(IDW'(i), 1'b0);
    exec_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1;
      tests++; if (exec_valid !== 1'b1 || exec_id !== IDW'(i) || exec_instr !== 32'hC000_0000 + 32'(i)) begin fails++; $display("[TB] FAIL full_wrap_order: got v%0b id %0d instr %0h expected v1 id %0d", exec_valid, exec_id, exec_instr, i); end
      @(posedge ck);
    end
    #1;
    tests++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL full_wrap_empty: got %0b expected 1", empty); end
    exec_ready = 1'b0;
  endtask

  task automatic test_out_of_order_commit();
    do_reset();
    do_issue(4'd1, 32'hD000_0001);
    do_issue(4'd2, 32'hD000_0002);
    do_commit(4'd2, 1'b0);
    tests++; if (exec_valid !== 1'b0) begin fails++; $display("[TB] FAIL ooo_head_blocks: got %0b expected 0", exec_valid); end
    do_commit(4'd9, 1'b0);
    tests++; if (exec_valid !== 1'b0 || count !== 3'd2) begin fails++; $display("[TB] FAIL ooo_unmatched: got v%0b count %0d expected 0 2", exec_valid, count); end
    do_commit(4'd1, 1'b0);
    tests++; if (exec_valid !== 1'b1 || exec_id !== 4'd1) begin fails++; $display("[TB] FAIL ooo_first: got v%0b id %0d expected v1 id 1", exec_valid, exec_id); end
    exec_ready = 1'b1;
    tick();
    tests++; if (exec_valid !== 1'b1 || exec_id !== 4'd2) begin fails++; $display("[TB] FAIL ooo_second: got v%0b id %0d expected v1 id 2", exec_valid, exec_id); end
    tick();
    tests++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL ooo_empty: got %0b expected 1", empty); end
    exec_ready = 1'b0;
  endtask

  task automatic test_kill();
    do_reset();
    do_issue(4'd3, 32'hE000_0003);
    do_issue(4'd4, 32'hE000_0004);
    do_commit(4'd4, 1'b0);
    inKillTest = 1'b1;
    sawKilledDispatch = 1'b0;
    exec_ready = 1'b1;
    do_commit(4'd3, 1'b1);
    tests++; if (exec_valid !== 1'b0 || count !== 3'd2) begin fails++; $display("[TB] FAIL kill_head: got v%0b count %0d expected 0 2", exec_valid, count); end
    tick();
    tests++; if (count !== 3'd1 || exec_valid !== 1'b1 || exec_id !== 4'd4) begin fails++; $display("[TB] FAIL kill_next: got count %0d v%0b id %0d expected 1 1 4", count, exec_valid, exec_id); end
    tick();
    tests++; if (empty !== 1'b1) begin fails++; $display("[TB] FAIL kill_empty: got %0b expected 1", empty); end
    inKillTest = 1'b0;
    tests++; if (sawKilledDispatch !== 1'b0) begin fails++; $display("[TB] FAIL kill_dispatched: got %0b expected 0", sawKilledDispatch); end
    exec_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_valid = 1'b1;
    pd_accept = 1'b1;
    issue_id = 4'd7;
    issue_instr = 32'hF000_0007;
    commit_valid = 1'b1;
    commit_id = 4'd7;
    tick();
    idle();
    tests++; if (exec_valid !== 1'b1 || exec_id !== 4'd7) begin fails++; $display("[TB] FAIL same_cycle_commit: got v%0b id %0d expected v1 id 7", exec_valid, exec_id); end
    exec_ready = 1'b1;
    issue_valid = 1'b1;
    pd_accept = 1'b1;
    issue_id = 4'd8;
    issue_instr = 32'hF000_0008;
    #1;
    tests++; if (issue_accept !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept: got %0b expected 1", issue_accept); end
    tick();
    idle();
    tests++; if (count !== 3'd1 || exec_valid !== 1'b0 || exec_id !== 4'd8) begin fails++; $display("[TB] FAIL b2b_push_pop: got count %0d v%0b id %0d expected 1 0 8", count, exec_valid, exec_id); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    do_issue(4'd1, 32'h1111_0001);
    do_issue(4'd2, 32'h1111_0002);
    do_issue(4'd3, 32'h1111_0003);
    do_commit(4'd1, 1'b0);
    tests++; if (count !== 3'd3 || exec_valid !== 1'b1) begin fails++; $display("[TB] FAIL midflight_pre: got count %0d v%0b expected 3 1", count, exec_valid); end
    rst = 1'b1;
    issue_valid = 1'b1;
    pd_accept = 1'b1;
    issue_id = 4'd4;
    commit_valid = 1'b1;
    commit_id = 4'd2;
    exec_ready = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    tests++; if (count !== 3'd0 || empty !== 1'b1) begin fails++; $display("[TB] FAIL midflight_count: got count %0d empty %0b expected 0 1", count, empty); end
    tests++; if (exec_valid !== 1'b0 || exec_id !== 4'd0) begin fails++; $display("[TB] FAIL midflight_exec: got v%0b id %0d expected 0 0", exec_valid, exec_id); end
`ifdef RVFPM_QUEUE_HWM_EN
    tests++; if (hwm !== 3'd0) begin fails++; $display("[TB] FAIL midflight_hwm: got %0d expected 0", hwm); end
`endif
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_in_order();
    test_reject();
    test_full_wrap();
    test_out_of_order_commit();
    test_kill();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_xif_issue_queue.md
FP_XIF_ISSUE_QUEUE -- requirements
Module: fp_xif_issue_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, giving the number of outstanding instruction entries (legal range 2..16).
REQ-002 SHALL have parameter X_ID_WIDTH, default 4, giving the CORE-V-XIF instruction ID width.
REQ-003 SHALL have parameter INSTR_WIDTH, default 32, giving the stored instruction word width.
REQ-004 SHALL have port: ck  in  1  clock, all state on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: issue_valid  in  1; issue_ready  out  1; issue_instr  in  INSTR_WIDTH; issue_id  in  X_ID_WIDTH -- XIF issue request.
REQ-007 SHALL have ports: pd_accept  in  1, combinational predecoder verdict for issue_instr; issue_accept  out  1, XIF issue response accept.
REQ-008 SHALL have ports: commit_valid  in  1; commit_id  in  X_ID_WIDTH; commit_kill  in  1 -- XIF commit.
REQ-009 SHALL have ports: exec_valid  out  1; exec_ready  in  1; exec_instr  out  INSTR_WIDTH; exec_id  out  X_ID_WIDTH -- dispatch to FPU execute.
REQ-010 SHALL have ports: count  out  $clog2(QUEUE_DEPTH+1); full  out  1; empty  out  1.

Function
REQ-011 SHALL hold a circular buffer of QUEUE_DEPTH entries {valid, committed, killed, instr, id} with head/tail pointers wrapping at QUEUE_DEPTH-1 -> 0.
REQ-012 SHALL drive issue_ready = !full, combinationally.
REQ-013 SHALL drive issue_accept = issue_valid && issue_ready && pd_accept; accepted transaction writes tail entry {valid=1, committed=0, killed=0} on next edge, tail+1.
REQ-014 SHALL leave all state unchanged on a rejected transaction (issue_valid && issue_ready && !pd_accept).
REQ-015 SHALL, on commit_valid, set committed=1 (and killed=commit_kill) on the valid uncommitted entry whose id equals commit_id; no match -> ignored, no error.
REQ-016 SHALL apply a commit arriving in the same cycle as the accepted issue of the same id to the newly written entry.
REQ-017 SHALL treat outstanding IDs as unique; on duplicates the entry nearest head matches.
REQ-018 SHALL drive exec_valid = head valid && committed && !killed; exec_instr/exec_id from head entry, combinationally (zero-latency dispatch from head).
REQ-019 SHALL pop head on exec_valid && exec_ready; SHALL pop a committed-killed head silently in one cycle with exec_valid=0.
REQ-020 SHALL never dispatch out of order: an uncommitted head blocks younger committed entries.
REQ-021 SHALL support push and pop in the same cycle with count unchanged; when full, no push occurs even if a pop occurs that cycle.
REQ-022 SHALL drive count = valid entries, full = (count==QUEUE_DEPTH), empty = (count==0), registered-state derived.

Reset
REQ-023 SHALL on rst clear all valid/committed/killed bits, head=tail=0, count=0, empty=1, full=0, issue_ready=1, exec_valid=0, exec_instr=0, exec_id=0 (plus hwm=0 when enabled).
REQ-024 SHALL make rst dominate same-cycle issue, commit and pop; in-flight entries are discarded.

Configuration
REQ-025 SHALL with macro RVFPM_QUEUE_HWM_EN defined add output hwm (width as count) holding the maximum count since reset, updated the cycle after count rises.
REQ-026 SHALL without RVFPM_QUEUE_HWM_EN omit hwm port and its register entirely; all other behaviour identical.

Structure
REQ-027 SHALL place the entry struct typedef and QUEUE_DEPTH range-check constants in package pa_rvfpm.
REQ-028 SHALL implement the commit ID match as sub-module fp_xif_id_match (one-hot match vector, head-priority select).

Verification
REQ-029 SHALL cover: depth 4, issue ids 1,2,3 accepted, commits 1,2,3, exec_ready=1 -> exec_id 1,2,3 on consecutive cycles, empty=1 after.
REQ-030 SHALL cover: issue id 5 with pd_accept=0 -> issue_accept=0, count stays 0, no dispatch.
REQ-031 SHALL cover: fill 4 entries -> full=1, issue_ready=0; 5th issue_valid held until one pop, then accepted; tail wraps to 0.
REQ-032 SHALL cover: ids 1,2 issued, commit 2 then commit 1 -> exec_id 1 then 2 (in-order); commit id 9 unmatched -> ignored.
REQ-033 SHALL cover: id 3 committed with commit_kill=1 at head -> silent pop, exec_valid never 1 for id 3, next entry dispatched after.
REQ-034 SHALL cover: rst asserted with count=3 -> next cycle count=0, exec_valid=0, hwm=0 when RVFPM_QUEUE_HWM_EN defined.
